path_history_ctrl: RTL and testbench
====================================

# path_history_ctrl

- Sequencer for the 12-bit speculative path-history register in the tournament predictor.
- Shifts the register once per accepted prediction and checkpoints its pre-shift value into an in-order FIFO.
- On an in-order branch resolution that mispredicted, reloads the register from the checkpoint corrected with the actual outcome, then flushes all younger checkpoints.
- Sits between the fetch/predict stage, the branch-resolve stage and the history register.

## Interface

Parameters:
- HIST_W, 12, history width
- DEPTH, 8, max in-flight unresolved branches (power of two, ≥2)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- pred_valid  in  1  prediction made this cycle
- pred_taken  in  1  predicted direction
- pred_ready  out  1  prediction may be accepted
- pred_tag  out  $clog2(DEPTH)  FIFO slot assigned to the accepted prediction
- resolve_valid  in  1  oldest in-flight branch resolves (program order)
- resolve_taken  in  1  actual direction
- resolve_mispredict  in  1  actual ≠ predicted
- resolve_ready  out  1  resolution may be accepted
- ph_cur  in  HIST_W  current history register value
- ph_shift  out  1  register shifts in ph_bit at MSB: {ph_bit, ph[HIST_W-1:1]}
- ph_bit  out  1  bit to shift in
- ph_load  out  1  register loads ph_load_val
- ph_load_val  out  HIST_W  recovery value
- occupancy  out  $clog2(DEPTH)+1  checkpoints held
- err_underflow  out  1  sticky: resolve accepted with FIFO empty

## Operation

- FSM states:
  - RUN: normal operation. Goes to RECOVER on an accepted mispredicting resolve; stays in RUN otherwise.
  - RECOVER: exactly one cycle, then back to RUN.
- Handshakes:
  - pred_ready = (state==RUN) && occupancy<DEPTH.
  - resolve_ready = (state==RUN).
- Accepted prediction (pred_valid && pred_ready), no mispredict in the same cycle:
  - ph_cur is written to the tail slot; pred_tag = tail index.
  - ph_shift=1, ph_bit=pred_taken (combinational, same cycle).
  - tail and occupancy increment.
- Accepted resolve, correct prediction:
  - Pop head; occupancy decrements.
- Accepted resolve, mispredict:
  - Register ph_load_val = {resolve_taken, head_checkpoint[HIST_W-1:1]}.
  - Flush the FIFO: head=tail=0, occupancy=0. Next state RECOVER.
- RECOVER:
  - ph_load=1, ph_shift=0; pred and resolve not accepted.
- Simultaneous events:
  - Pred + correct resolve: both take effect; occupancy unchanged when not empty. At full, pred_ready=0 regardless of the pop.
  - Pred + mispredict resolve: the mispredict wins. The pred is handshaken but discarded: no shift, no checkpoint.
- Resolve with FIFO empty: no pop, no recovery even if mispredict flagged; err_underflow set until reset.
- Wrap-around: head/tail are modulo DEPTH. Full is detected by occupancy, never by pointer equality alone.
- ph_shift and ph_load are never asserted together.

## Timing

- Reset values: state=RUN, head=tail=0, occupancy=0, ph_load=0, ph_load_val=0, err_underflow=0, pred_ready=1, resolve_ready=1, pred_tag=0, ph_shift=0.
- Shift path is combinational. The register holds the new value at the next edge, so back-to-back predictions checkpoint correct values.
- Recovery latency:
  - Mispredict accepted in cycle N.
  - ph_load asserted in N+1.
  - Corrected history on ph_cur in N+2.
  - pred_ready/resolve_ready return to 1 in N+2.
- Reset mid-RECOVER: ph_load deasserts immediately and all checkpoints are lost.

## Structure

- Package bp_pkg:
  - HIST_W constant.
  - ph_t typedef (logic [HIST_W-1:0]).
  - phc_state_e enum {RUN, RECOVER}.
- Sub-module ph_checkpoint_fifo:
  - DEPTH×HIST_W storage.
  - Push, pop and flush ports, with occupancy.
- The controller holds the FSM, handshakes and recovery register.

## Test plan

- Reset, then 3 preds (taken, not-taken, taken) with ph_cur tracking an external model from 0 -> ph_shift pulses each cycle, tags 0,1,2, occupancy=3, checkpoints 0x000, 0x800, 0x400.
- Fill 8 preds without resolves -> pred_ready=0 at occupancy 8. Ninth pred_valid causes no shift. One correct resolve restores pred_ready next cycle.
- Preds with ph_cur=0xA5C before the first; first resolve mispredicts with taken=0 -> ph_load=1 one cycle later with ph_load_val=0x52E, occupancy=0, ready low for one cycle.
- Same-cycle pred + mispredicting resolve -> no ph_shift, recovery proceeds, occupancy=0 after.
- Push/pop streaming for 20 cycles at occupancy 1 -> pointers wrap past 7, tags cycle 0..7, all checkpoints match the model.
- Resolve on empty FIFO -> err_underflow=1 and stays set. Async reset asserted during RECOVER -> all outputs at their reset values immediately.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor path-history logic.
package bp_pkg;

  localparam int HIST_W = 12;

  typedef logic [HIST_W-1:0] ph_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } phc_state_e;

endpackage : bp_pkg

// File: rtl/ph_checkpoint_fifo.sv
// In-order FIFO of pre-shift path-history checkpoints, one per in-flight branch.
// Flush takes priority over push and pop and empties the FIFO in one cycle.
module ph_checkpoint_fifo #(
  parameter int HIST_W = 12,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [HIST_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [HIST_W-1:1] head_upper,
  output logic [PTR_W-1:0]  tail_idx,
  output logic [PTR_W:0]    occupancy
);

  logic [HIST_W-1:0] mem_q [DEPTH];
  logic [HIST_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    occ_q, occ_d;

  // Only the upper bits of the oldest checkpoint matter for recovery.
  assign head_upper = mem_q[head_q][HIST_W-1:1];
  assign tail_idx   = tail_q;
  assign occupancy  = occ_q;

  // Next-state for storage and pointers; pointers wrap naturally at DEPTH.
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      occ_d = occ_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule : ph_checkpoint_fifo

// File: rtl/path_history_ctrl.sv
// Sequencer for the speculative path-history register: shifts on each accepted
// prediction, checkpoints the pre-shift value, and on a mispredicting in-order
// resolve reloads the register from the corrected checkpoint one cycle later.
module path_history_ctrl #(
  parameter int HIST_W = bp_pkg::HIST_W,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pred_valid,
  input  logic              pred_taken,
  output logic              pred_ready,
  output logic [PTR_W-1:0]  pred_tag,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  input  logic              resolve_mispredict,
  output logic              resolve_ready,
  input  logic [HIST_W-1:0] ph_cur,
  output logic              ph_shift,
  output logic              ph_bit,
  output logic              ph_load,
  output logic [HIST_W-1:0] ph_load_val,
  output logic [PTR_W:0]    occupancy,
  output logic              err_underflow
);

  import bp_pkg::*;

  phc_state_e        state_q, state_d;
  logic              ph_load_q, ph_load_d;
  logic [HIST_W-1:0] ph_load_val_q, ph_load_val_d;
  logic              err_underflow_q, err_underflow_d;

  logic              fifo_empty;
  logic              fifo_full;
  logic              pred_acc;
  logic              res_acc;
  logic              res_mispredict;
  logic              res_correct;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic [HIST_W-1:1] head_upper;

  ph_checkpoint_fifo #(
    .HIST_W (HIST_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (fifo_push),
    .push_data  (ph_cur),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .head_upper (head_upper),
    .tail_idx   (pred_tag),
    .occupancy  (occupancy)
  );

  // Handshakes and event decode; a mispredict outranks a same-cycle prediction,
  // and a resolve on an empty FIFO neither pops nor recovers.
  always_comb begin
    fifo_empty     = (occupancy == '0);
    fifo_full      = (occupancy == (PTR_W+1)'(DEPTH));
    pred_ready     = (state_q == RUN) && !fifo_full;
    resolve_ready  = (state_q == RUN);
    pred_acc       = pred_valid && pred_ready;
    res_acc        = resolve_valid && resolve_ready;
    res_mispredict = res_acc && !fifo_empty && resolve_mispredict;
    res_correct    = res_acc && !fifo_empty && !resolve_mispredict;
    fifo_push      = pred_acc && !res_mispredict;
    fifo_pop       = res_correct;
    fifo_flush     = res_mispredict;
    ph_shift       = fifo_push;
    ph_bit         = pred_taken;
  end

  // FSM next state, recovery value and sticky underflow flag.
  always_comb begin
    state_d         = state_q;
    ph_load_d       = 1'b0;
    ph_load_val_d   = ph_load_val_q;
    err_underflow_d = err_underflow_q | (res_acc && fifo_empty);
    case (state_q)
      RUN: begin
        if (res_mispredict) begin
          state_d       = RECOVER;
          ph_load_d     = 1'b1;
          ph_load_val_d = {resolve_taken, head_upper};
        end
      end
      RECOVER: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // FSM state and registered recovery outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= RUN;
      ph_load_q       <= 1'b0;
      ph_load_val_q   <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ph_load_q       <= ph_load_d;
      ph_load_val_q   <= ph_load_val_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign ph_load       = ph_load_q;
  assign ph_load_val   = ph_load_val_q;
  assign err_underflow = err_underflow_q;

endmodule : path_history_ctrl

// File: tb/tb_path_history_ctrl.sv
// Self-checking bench for path_history_ctrl with an external history register
// and a queue-based reference model.
module tb_path_history_ctrl;

  localparam int HW    = 12;
  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH);

  logic          clock;
  logic          reset;
  logic          pred_valid;
  logic          pred_taken;
  logic          pred_ready;
  logic [PW-1:0] pred_tag;
  logic          resolve_valid;
  logic          resolve_taken;
  logic          resolve_mispredict;
  logic          resolve_ready;
  logic [HW-1:0] ph_cur;
  logic          ph_shift;
  logic          ph_bit;
  logic          ph_load;
  logic [HW-1:0] ph_load_val;
  logic [PW:0]   occupancy;
  logic          err_underflow;

  logic          preset_en;
  logic [HW-1:0] preset_val;

  int n_checks;
  int n_fail;

  // Reference model state
  int m_q[$];
  bit m_rec;
  bit m_err;
  int m_hist;
  int m_load_val;
  int m_tail;

  typedef struct {
    bit pv, pt, rv, rt, rm;
    bit exp_shift;
    int exp_tag;
    int exp_occ;
    int exp_ph;
    bit exp_rdy;
    bit exp_load;
    int exp_lv;
  } vec_t;

  vec_t tbl[8];

  path_history_ctrl #(.HIST_W(HW), .DEPTH(DEPTH)) dut (
    .clock              (clock),
    .reset              (reset),
    .pred_valid         (pred_valid),
    .pred_taken         (pred_taken),
    .pred_ready         (pred_ready),
    .pred_tag           (pred_tag),
    .resolve_valid      (resolve_valid),
    .resolve_taken      (resolve_taken),
    .resolve_mispredict (resolve_mispredict),
    .resolve_ready      (resolve_ready),
    .ph_cur             (ph_cur),
    .ph_shift           (ph_shift),
    .ph_bit             (ph_bit),
    .ph_load            (ph_load),
    .ph_load_val        (ph_load_val),
    .occupancy          (occupancy),
    .err_underflow      (err_underflow)
  );

  // Clock generator
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // The history register the controller steers
  always @(posedge clock or posedge reset) begin
    if (reset)          ph_cur <= '0;
    else if (preset_en) ph_cur <= preset_val;
    else if (ph_load)   ph_cur <= ph_load_val;
    else if (ph_shift)  ph_cur <= {ph_bit, ph_cur[HW-1:1]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rec      = 1'b0;
    m_err      = 1'b0;
    m_hist     = 0;
    m_load_val = 0;
    m_tail     = 0;
  endtask

  task automatic apply_stimulus(input bit pv, input bit pt, input bit rv, input bit rt, input bit rm);
    @(negedge clock);
    pred_valid         = pv;
    pred_taken         = pt;
    resolve_valid      = rv;
    resolve_taken      = rt;
    resolve_mispredict = rm;
    preset_en          = 1'b0;
    #1;
  endtask

  task automatic check_output();
    bit exp_shift;
    int n;
    n = m_q.size();
    exp_shift = !m_rec && pred_valid && (n < DEPTH) &&
                !(resolve_valid && n > 0 && resolve_mispredict);
    chk("pred_ready",    pred_ready,    32'(!m_rec && n < DEPTH));
    chk("resolve_ready", resolve_ready, 32'(!m_rec));
    chk("occupancy",     occupancy,     n);
    chk("pred_tag",      pred_tag,      m_tail % DEPTH);
    chk("ph_load",       ph_load,       32'(m_rec));
    chk("ph_load_val",   ph_load_val,   m_load_val);
    chk("err_underflow", err_underflow, 32'(m_err));
    chk("ph_cur",        ph_cur,        m_hist);
    chk("ph_shift",      ph_shift,      32'(exp_shift));
    if (exp_shift) chk("ph_bit", ph_bit, 32'(pred_taken));
  endtask

  task automatic advance_model();
    bit pacc, racc, mis;
    int n;
    if (m_rec) begin
      m_rec  = 1'b0;
      m_hist = m_load_val;
    end else begin
      n    = m_q.size();
      pacc = pred_valid && (n < DEPTH);
      racc = resolve_valid;
      if (racc && n == 0) m_err = 1'b1;
      mis = racc && n > 0 && resolve_mispredict;
      if (mis) begin
        m_load_val = (resolve_taken ? (1 << (HW-1)) : 0) | (m_q[0] >> 1);
        m_q.delete();
        m_tail = 0;
        m_rec  = 1'b1;
      end else begin
        if (racc && n > 0) void'(m_q.pop_front());
        if (pacc) begin
          m_q.push_back(m_hist);
          m_tail++;
          m_hist = (pred_taken ? (1 << (HW-1)) : 0) | (m_hist >> 1);
        end
      end
    end
    if (preset_en) m_hist = int'(preset_val);
  endtask

  task automatic cycle(input bit pv, input bit pt, input bit rv, input bit rt, input bit rm);
    apply_stimulus(pv, pt, rv, rt, rm);
    check_output();
    advance_model();
    @(posedge clock);
  endtask

  task automatic cycle_preset(input logic [HW-1:0] val);
    apply_stimulus(0, 0, 0, 0, 0);
    preset_en  = 1'b1;
    preset_val = val;
    check_output();
    advance_model();
    @(posedge clock);
  endtask

  // Caller positions time away from the clock edge before calling
  task automatic apply_reset();
    reset              = 1'b1;
    pred_valid         = 1'b0;
    pred_taken         = 1'b0;
    resolve_valid      = 1'b0;
    resolve_taken      = 1'b0;
    resolve_mispredict = 1'b0;
    preset_en          = 1'b0;
    #1;
    chk("rst_ph_load",       ph_load,       0);
    chk("rst_ph_load_val",   ph_load_val,   0);
    chk("rst_pred_ready",    pred_ready,    1);
    chk("rst_resolve_ready", resolve_ready, 1);
    chk("rst_occupancy",     occupancy,     0);
    chk("rst_pred_tag",      pred_tag,      0);
    chk("rst_ph_shift",      ph_shift,      0);
    chk("rst_err_underflow", err_underflow, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    preset_en  = 1'b0;
    preset_val = '0;
    model_reset();

    // pv pt rv rt rm | shift tag occ ph rdy load lv
    tbl[0] = '{1,1,0,0,0, 1, 0, 0, 'h000, 1, 0, 'h000};
    tbl[1] = '{1,0,0,0,0, 1, 1, 1, 'h800, 1, 0, 'h000};
    tbl[2] = '{1,1,0,0,0, 1, 2, 2, 'h400, 1, 0, 'h000};
    tbl[3] = '{0,0,0,0,0, 0, 3, 3, 'hA00, 1, 0, 'h000};
    tbl[4] = '{0,0,1,1,0, 0, 3, 3, 'hA00, 1, 0, 'h000};
    tbl[5] = '{0,0,1,0,1, 0, 3, 2, 'hA00, 1, 0, 'h000};
    tbl[6] = '{0,0,0,0,0, 0, 0, 0, 'hA00, 0, 1, 'h400};
    tbl[7] = '{0,0,0,0,0, 0, 0, 0, 'h400, 1, 0, 'h400};

    #1;
    @(negedge clock);
    apply_reset();

    // Directed table: three predictions, a correct resolve, then a mispredict
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(tbl[i].pv, tbl[i].pt, tbl[i].rv, tbl[i].rt, tbl[i].rm);
      chk($sformatf("tbl%0d_shift", i), ph_shift,    32'(tbl[i].exp_shift));
      chk($sformatf("tbl%0d_tag", i),   pred_tag,    tbl[i].exp_tag);
      chk($sformatf("tbl%0d_occ", i),   occupancy,   tbl[i].exp_occ);
      chk($sformatf("tbl%0d_ph", i),    ph_cur,      tbl[i].exp_ph);
      chk($sformatf("tbl%0d_rdy", i),   pred_ready,  32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_load", i),  ph_load,     32'(tbl[i].exp_load));
      chk($sformatf("tbl%0d_lv", i),    ph_load_val, tbl[i].exp_lv);
      check_output();
      advance_model();
      @(posedge clock);
    end

    // Fill to DEPTH, overflow attempt, pred+pop at full, then ready returns
    for (int i = 0; i < DEPTH; i++) cycle(1, 1'($urandom_range(1)), 0, 0, 0);
    apply_stimulus(1, 1, 0, 0, 0);
    chk("full_pred_ready", pred_ready, 0);
    chk("full_no_shift",   ph_shift,   0);
    check_output();
    advance_model();
    @(posedge clock);
    cycle(1, 0, 1, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    chk("after_pop_ready", pred_ready, 1);
    chk("after_pop_occ",   occupancy,  DEPTH - 1);
    check_output();
    advance_model();
    @(posedge clock);
    cycle(0, 0, 1, 1, 1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Recovery from a known checkpoint value
    cycle_preset(12'hA5C);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0);
    chk("rec_ph_load",     ph_load,       1);
    chk("rec_ph_load_val", ph_load_val,   'h52E);
    chk("rec_occ",         occupancy,     0);
    chk("rec_pred_ready",  pred_ready,    0);
    chk("rec_res_ready",   resolve_ready, 0);
    check_output();
    advance_model();
    @(posedge clock);
    apply_stimulus(0, 0, 0, 0, 0);
    chk("rec_ph_cur",      ph_cur,        'h52E);
    chk("rec_ready_back",  pred_ready,    1);
    check_output();
    advance_model();
    @(posedge clock);

    // Same-cycle prediction and mispredicting resolve
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    apply_stimulus(1, 1, 1, 1, 1);
    chk("same_cycle_no_shift", ph_shift, 0);
    check_output();
    advance_model();
    @(posedge clock);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Streaming at occupancy 1 so the pointers wrap repeatedly
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 1'($urandom_range(1)), 1, 1, 0);
    cycle(0, 0, 1, 1'($urandom_range(1)), 1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Resolve on empty FIFO with mispredict flagged: no recovery, sticky error
    cycle(0, 0, 1, 1, 1);
    apply_stimulus(0, 0, 0, 0, 0);
    chk("underflow_set",     err_underflow, 1);
    chk("underflow_no_load", ph_load,       0);
    check_output();
    advance_model();
    @(posedge clock);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, 1'($urandom_range(1)), ($urandom % 3) == 0,
            1'($urandom_range(1)), ($urandom % 8) == 0);
    end

    // Asynchronous reset in the middle of recovery
    @(negedge clock);
    apply_reset();
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 1);
    @(negedge clock);
    #1;
    chk("midrec_ph_load_before", ph_load, 1);
    apply_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_path_history_ctrl
